// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : requester/response bundle shared by the ALU arbiter.
// Rev 1.0
// ============================================================================
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_data;
  logic                 rsp_err;

  // Requester side: drives requests, consumes responses.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin sharing of one ALU, one op in flight, with
//               illegal-opcode screening and a stuck-ALU timeout.
// Rev 1.0
// ============================================================================
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy,
  output logic          alu_en,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_op,
  input  logic [15:0]   alu_result,
  input  logic          alu_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("alu_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [ID_W-1:0]  ptr_q,       ptr_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q,   rsp_err_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [15:0]      rsp_data_q,  rsp_data_d;
  logic             busy_q,      busy_d;
  logic             alu_en_q,    alu_en_d;
  logic [7:0]       alu_a_q,     alu_a_d;
  logic [7:0]       alu_b_q,     alu_b_d;
  logic [2:0]       alu_op_q,    alu_op_d;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      grant_next;
  logic [7:0]           sel_a;
  logic [7:0]           sel_b;
  logic [2:0]           sel_op;
  logic                 sel_legal;

  // Rotate the valid vector so bit 0 is the pointer position; the lowest set
  // bit of the rotated vector is the round-robin winner.
  always_comb begin : arb_search
    valid_dbl   = {bus.req_valid, bus.req_valid} >> ptr_q;
    valid_rot   = valid_dbl[NUM_REQ-1:0];
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    grant_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin : operand_sel
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_a  = bus.req_a[8*k +: 8];
        sel_b  = bus.req_b[8*k +: 8];
        sel_op = bus.req_op[3*k +: 3];
      end
    end
    sel_legal = (sel_op <= 3'd5);
  end

  always_comb begin : ready_gen
    bus.req_ready = '0;
    if (state_q == S_IDLE && grant_found) begin
      bus.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    alu_en_d    = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          ptr_d    = grant_next;
          rsp_id_d = grant_idx;
          if (sel_legal) begin
            state_d  = S_ISSUE;
            alu_en_d = 1'b1;
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
          end else begin
            // Illegal opcode never reaches the ALU.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (alu_done) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = alu_result;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end

      S_RESP: begin
        // No arbitration here: the next grant waits for a full IDLE cycle.
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      alu_en_q    <= alu_en_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;
  assign alu_en        = alu_en_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : randomized self-checking bench with an arbitration/ALU model.
// Rev 1.0
// ============================================================================
module tb_alu_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  logic        busy, alu_en, alu_done;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .alu_en     (alu_en),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_done   (alu_done)
  );

  int checks = 0;
  int passed = 0;
  int ptr_m  = 0;
  int txn_no = 0;
  int grant_log[$];

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return 16'(a) + 16'(b);
      3'd1:    return 16'(a) * 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a | b};
      3'd4:    return {8'h00, a ^ b};
      3'd5:    return {8'h00, ~a};
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] mask);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(ptr_m + k) % NUM_REQ]) return (ptr_m + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [11:0] rand_ops(input bit legal_only);
    logic [11:0] r;
    for (int i = 0; i < NUM_REQ; i++)
      r[3*i +: 3] = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
    return r;
  endfunction

  // Behavioural ALU: result after alu_lat cycles, or never when stuck.
  int          alu_lat    = 1;
  bit          alu_stuck  = 1'b0;
  int          alu_en_cnt = 0;
  int          pend       = 0;
  logic [15:0] pend_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_done   <= 1'b0;
      alu_result <= '0;
      pend       = 0;
    end else begin
      alu_done <= 1'b0;
      if (alu_en) begin
        alu_en_cnt++;
        pend_res = alu_fn(alu_a, alu_b, alu_op);
        pend     = alu_lat;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !alu_stuck) begin
          alu_done   <= 1'b1;
          alu_result <= pend_res;
        end
      end
    end
  end

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ptr_m = 0;
  endtask

  // One transaction, entered and left at posedge+1 with the arbiter idle.
  task automatic run_txn(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] op, input int hold, input int exp_const);
    int g, cyc, en0, exp_lat;
    logic [7:0] ga, gb;
    logic [2:0] gop;
    logic exp_err;
    logic [15:0] exp_data;
    txn_no++;
    g   = pick(mask);
    ga  = 8'(a >> (8*g));
    gb  = 8'(b >> (8*g));
    gop = 3'(op >> (3*g));
    exp_err  = (gop >= 3'd6) || alu_stuck;
    exp_data = exp_err ? 16'h0000 : alu_fn(ga, gb, gop);
    exp_lat  = (gop >= 3'd6) ? 1 : (alu_stuck ? TIMEOUT + 2 : alu_lat + 2);
    en0 = alu_en_cnt;
    grant_log.push_back(g);

    bus.req_valid = mask;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_op = op;
    #1;
    checks++;
    if (bus.req_ready !== 4'(1 << g))
      $display("FAIL grant txn%0d: req_ready=%b expected %b", txn_no, bus.req_ready, 4'(1 << g));
    else passed++;
    ptr_m = (g + 1) % NUM_REQ;

    @(posedge clk); #1; cyc = 1;
    checks++;
    if ({bus.req_ready, busy} !== {4'b0000, 1'b1})
      $display("FAIL ready_one_cycle txn%0d: req_ready=%b busy=%b expected 0000/1",
               txn_no, bus.req_ready, busy);
    else passed++;
    checks++;
    if (gop < 3'd6 && {alu_en, alu_a, alu_b, alu_op} !== {1'b1, ga, gb, gop})
      $display("FAIL issue txn%0d: en=%b a=%h b=%h op=%0d expected 1 %h %h %0d",
               txn_no, alu_en, alu_a, alu_b, alu_op, ga, gb, gop);
    else if (gop >= 3'd6 && alu_en !== 1'b0)
      $display("FAIL issue txn%0d: alu_en=%b expected 0 for illegal op", txn_no, alu_en);
    else passed++;
    bus.req_valid = '0;
    bus.req_a = {$urandom, $urandom};
    bus.req_b = $urandom;

    while (bus.rsp_valid !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != exp_lat)
      $display("FAIL latency txn%0d: rsp_valid after %0d cycles expected %0d", txn_no, cyc, exp_lat);
    else passed++;
    checks++;
    if ({bus.rsp_id, bus.rsp_err, bus.rsp_data} !== {ID_W'(g), exp_err, exp_data})
      $display("FAIL response txn%0d: id=%0d err=%b data=%h expected id=%0d err=%b data=%h",
               txn_no, bus.rsp_id, bus.rsp_err, bus.rsp_data, g, exp_err, exp_data);
    else passed++;
    if (exp_const >= 0) begin
      checks++;
      if (bus.rsp_data !== 16'(exp_const))
        $display("FAIL known_value txn%0d: data=%h expected %h", txn_no, bus.rsp_data, 16'(exp_const));
      else passed++;
    end
    checks++;
    if (alu_en_cnt - en0 != ((gop >= 3'd6) ? 0 : 1))
      $display("FAIL alu_en_count txn%0d: %0d pulses expected %0d", txn_no, alu_en_cnt - en0,
               (gop >= 3'd6) ? 0 : 1);
    else passed++;

    if (hold > 0) begin
      bus.req_valid = 4'b1000;
      repeat (hold) begin
        @(posedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, bus.req_ready, busy} !==
            {1'b1, ID_W'(g), exp_err, exp_data, 4'b0000, 1'b1})
          $display("FAIL hold txn%0d: valid=%b id=%0d err=%b data=%h ready=%b busy=%b expected 1 %0d %b %h 0000 1",
                   txn_no, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, bus.req_ready, busy,
                   g, exp_err, exp_data);
        else passed++;
      end
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00)
      $display("FAIL release txn%0d: rsp_valid=%b busy=%b expected 0 0", txn_no, bus.rsp_valid, busy);
    else passed++;
    if (hold > 0) begin
      // Waiting requester is granted only in the IDLE cycle after release, then withdraws.
      checks++;
      if (bus.req_ready !== 4'b1000)
        $display("FAIL post_release_grant txn%0d: req_ready=%b expected 1000", txn_no, bus.req_ready);
      else passed++;
      bus.req_valid = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, busy, alu_en,
         alu_a, alu_b, alu_op} !== '0)
      $display("FAIL reset_outputs: ready=%b rv=%b id=%0d data=%h err=%b busy=%b en=%b a=%h b=%h op=%0d expected all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, busy, alu_en,
               alu_a, alu_b, alu_op);
    else passed++;
    rst_n = 1'b1;
    ptr_m = 0;
    @(posedge clk); #1;
    checks++;
    if ({busy, bus.rsp_valid, alu_en} !== 3'b000)
      $display("FAIL idle_after_reset: busy=%b rv=%b en=%b expected 0", busy, bus.rsp_valid, alu_en);
    else passed++;
  endtask

  task automatic test_basic_ops();
    alu_lat = 1;
    run_txn(4'b0001, 32'd200, 32'd100, 12'd0, 0, 'h012C);
    run_txn(4'b0100, 32'(255) << 16, 32'(255) << 16, 12'(1) << 6, 0, 'hFE01);
    run_txn(4'b0100, 32'h0F << 16, $urandom, 12'(5) << 6, 0, 'h00F0);
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    grant_log.delete();
    repeat (5) run_txn(4'hF, $urandom, $urandom, rand_ops(1'b1), 0, -1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (grant_log[i] != exp_order[i])
        $display("FAIL rr_order[%0d]: granted %0d expected %0d", i, grant_log[i], exp_order[i]);
      else passed++;
    end
  endtask

  task automatic test_illegal_op();
    run_txn(4'b0010, $urandom, $urandom, 12'(6) << 3, 0, 0);
    run_txn(4'b1000, $urandom, $urandom, 12'(7) << 9, 0, 0);
  endtask

  task automatic test_timeout();
    alu_stuck = 1'b1;
    run_txn(4'b0001, $urandom, $urandom, 12'd0, 0, 0);
    alu_stuck = 1'b0;
    run_txn(4'b0001, 32'd3, 32'd4, 12'd0, 0, 7);
  endtask

  task automatic test_backpressure();
    run_txn(4'b0001, $urandom, $urandom, rand_ops(1'b1), 5, -1);
  endtask

  task automatic test_reset_mid_op();
    run_txn(4'b0010, $urandom, $urandom, rand_ops(1'b1), 0, -1);
    alu_stuck = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_op = '0;
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, busy, alu_en,
         alu_a, alu_b, alu_op} !== '0)
      $display("FAIL reset_mid_op: rv=%b id=%0d data=%h err=%b busy=%b en=%b a=%h b=%h op=%0d expected all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, busy, alu_en, alu_a, alu_b, alu_op);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    alu_stuck = 1'b0;
    ptr_m = 0;
    run_txn(4'hF, $urandom, $urandom, rand_ops(1'b1), 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      alu_lat = $urandom_range(1, 3);
      run_txn(4'($urandom_range(1, 15)), $urandom, $urandom, rand_ops(1'b0),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, -1);
    end
    alu_lat = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_ops();
    test_round_robin();
    test_illegal_op();
    test_timeout();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
